// File: rtl/aclint_memory.sv
// aclint_memory: memory-mapped ACLINT timer / software-interrupt device.
// Owns mtime, mtimecmp and msip; acts as a membus slave at BASE_ADDR and
// drives mtip/msip/mtime toward the core's CSR unit.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   membus_valid/ready        request handshake (ready tied high)
//   membus_addr/wen/wdata/wmask  request payload (8-byte words, byte enables)
//   membus_rvalid/rdata       registered response, one cycle after accept
//   mtip, msip, mtime         interrupt/timer outputs to the CSR unit
module aclint_memory #(
  parameter logic [63:0] BASE_ADDR = 64'h0200_0000,
  parameter int unsigned MTIME_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        membus_valid,
  output logic        membus_ready,
  input  logic [63:0] membus_addr,
  input  logic        membus_wen,
  input  logic [63:0] membus_wdata,
  input  logic [7:0]  membus_wmask,
  output logic        membus_rvalid,
  output logic [63:0] membus_rdata,
  output logic        mtip,
  output logic        msip,
  output logic [63:0] mtime
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned PW   = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;
  localparam int unsigned WW   = 13;

  localparam logic [XLEN-1:0] WIN_SIZE   = 64'h0000_0000_0001_0000;
  localparam logic [WW-1:0]   MSIP_WORD  = 13'h0000;
  localparam logic [WW-1:0]   CMP_WORD   = 13'h0800;
  localparam logic [WW-1:0]   MTIME_WORD = 13'h17FF;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(MTIME_DIV - 1);

  logic            msip_reg;
  logic [XLEN-1:0] mtimecmp;
  logic [XLEN-1:0] mtime_reg;
  logic [PW-1:0]   presc;

  logic [XLEN-1:0] off_c;
  logic            in_win_c;
  logic [WW-1:0]   word_c;
  logic            accept_c;
  logic [XLEN-1:0] bytemask_c;
  logic [XLEN-1:0] rd_c;
  logic            wr_msip_c;
  logic            wr_cmp_c;
  logic            wr_mtime_c;
  logic            unused_lsb;

  assign membus_ready = 1'b1;
  assign accept_c     = membus_valid & membus_ready;

  // Unsigned subtraction makes addresses below the base wrap out of the window.
  assign off_c      = membus_addr - BASE_ADDR;
  assign in_win_c   = (off_c < WIN_SIZE);
  assign word_c     = off_c[15:3];
  assign unused_lsb = ^off_c[2:0];

  // Expand byte enables into a bit mask.
  always_comb begin
    bytemask_c = '0;
    for (int i = 0; i < 8; i++) begin
      bytemask_c[8*i +: 8] = {8{membus_wmask[i]}};
    end
  end

  // Address decode and read mux (pre-edge register values).
  always_comb begin
    rd_c       = '0;
    wr_msip_c  = 1'b0;
    wr_cmp_c   = 1'b0;
    wr_mtime_c = 1'b0;
    if (accept_c && in_win_c) begin
      case (word_c)
        MSIP_WORD: begin
          wr_msip_c = membus_wen;
          rd_c      = membus_wen ? '0 : {{(XLEN-1){1'b0}}, msip_reg};
        end
        CMP_WORD: begin
          wr_cmp_c = membus_wen;
          rd_c     = membus_wen ? '0 : mtimecmp;
        end
        MTIME_WORD: begin
          wr_mtime_c = membus_wen;
          rd_c       = membus_wen ? '0 : mtime_reg;
        end
        default: rd_c = '0;
      endcase
    end
  end

  // Register state, response pipeline and mtime prescaler.
  always_ff @(posedge clk) begin
    if (rst) begin
      msip_reg      <= 1'b0;
      mtimecmp      <= '1;
      mtime_reg     <= '0;
      presc         <= '0;
      membus_rvalid <= 1'b0;
      membus_rdata  <= '0;
    end else begin
      membus_rvalid <= accept_c;
      membus_rdata  <= rd_c;

      if (wr_msip_c && membus_wmask[0]) begin
        msip_reg <= membus_wdata[0];
      end

      if (wr_cmp_c) begin
        mtimecmp <= (mtimecmp & ~bytemask_c) | (membus_wdata & bytemask_c);
      end

      // A software write to mtime overrides the tick and restarts the prescaler.
      if (wr_mtime_c) begin
        mtime_reg <= (mtime_reg & ~bytemask_c) | (membus_wdata & bytemask_c);
        presc     <= '0;
      end else if (presc == PRESC_LAST) begin
        mtime_reg <= mtime_reg + XLEN'(1);
        presc     <= '0;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  assign mtime = mtime_reg;
  assign msip  = msip_reg;
  assign mtip  = (mtime_reg >= mtimecmp);

endmodule

// File: tb/tb_aclint_memory.sv
// tb_aclint_memory: directed plus randomized bench for aclint_memory.
// Two instances (MTIME_DIV=1 and MTIME_DIV=4) share one request bus and are
// each compared every cycle against a behavioural model in which mtime is
// computed as (value at last set) + elapsed_cycles / DIV.
module tb_aclint_memory;

  localparam logic [63:0] BASE = 64'h0200_0000;
  localparam logic [63:0] A_MSIP  = BASE + 64'h0000;
  localparam logic [63:0] A_CMP   = BASE + 64'h4000;
  localparam logic [63:0] A_MTIME = BASE + 64'hBFF8;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [63:0] addr = '0;
  logic        wen = 1'b0;
  logic [63:0] wdata = '0;
  logic [7:0]  wmask = '0;

  logic        ready1, rvalid1, mtip1, msip1;
  logic [63:0] rdata1, mtime1;
  logic        ready4, rvalid4, mtip4, msip4;
  logic [63:0] rdata4, mtime4;

  always #5 clk = ~clk;

  aclint_memory #(.BASE_ADDR(BASE), .MTIME_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .membus_valid(valid), .membus_ready(ready1),
    .membus_addr(addr), .membus_wen(wen), .membus_wdata(wdata),
    .membus_wmask(wmask), .membus_rvalid(rvalid1), .membus_rdata(rdata1),
    .mtip(mtip1), .msip(msip1), .mtime(mtime1)
  );

  aclint_memory #(.BASE_ADDR(BASE), .MTIME_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .membus_valid(valid), .membus_ready(ready4),
    .membus_addr(addr), .membus_wen(wen), .membus_wdata(wdata),
    .membus_wmask(wmask), .membus_rvalid(rvalid4), .membus_rdata(rdata4),
    .mtip(mtip4), .msip(msip4), .mtime(mtime4)
  );

  // Behavioural model state.
  longint unsigned cyc = 0;
  logic [63:0]     m_base [2];
  longint unsigned m_t0   [2];
  longint unsigned m_div  [2];
  logic [63:0]     m_cmp;
  logic            m_msip;
  logic            e_rvalid;
  logic [63:0]     e_rdata [2];

  int n_total = 0;
  int n_fail  = 0;

  function automatic logic [63:0] mt(input int i);
    return m_base[i] + 64'((64'(cyc) - 64'(m_t0[i])) / 64'(m_div[i]));
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                        input logic [7:0] wm);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (wm[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // 0 = MSIP, 1 = MTIMECMP, 2 = MTIME, 3 = unmapped.
  function automatic int region(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
    if (a < BASE || a >= BASE + 64'h1_0000) return 3;
    case ({off[15:3], 3'b000})
      16'h0000: return 0;
      16'h4000: return 1;
      16'hBFF8: return 2;
      default:  return 3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, update the model from the inputs seen at the edge, then compare.
  task automatic tick();
    logic [63:0] pre [2];
    logic        s_rst, s_valid, s_wen;
    logic [63:0] s_addr, s_wdata;
    logic [7:0]  s_wmask;
    int          reg_sel;
    for (int i = 0; i < 2; i++) pre[i] = mt(i);
    s_rst = rst; s_valid = valid; s_wen = wen;
    s_addr = addr; s_wdata = wdata; s_wmask = wmask;
    @(posedge clk);
    #1;
    cyc++;
    e_rvalid   = 1'b0;
    e_rdata[0] = '0;
    e_rdata[1] = '0;
    if (s_rst) begin
      for (int i = 0; i < 2; i++) begin
        m_base[i] = '0;
        m_t0[i]   = cyc;
      end
      m_cmp  = ONES;
      m_msip = 1'b0;
    end else if (s_valid) begin
      e_rvalid = 1'b1;
      reg_sel  = region(s_addr);
      if (!s_wen) begin
        for (int i = 0; i < 2; i++) begin
          case (reg_sel)
            0: e_rdata[i] = {63'b0, m_msip};
            1: e_rdata[i] = m_cmp;
            2: e_rdata[i] = pre[i];
            default: e_rdata[i] = '0;
          endcase
        end
      end else begin
        case (reg_sel)
          0: if (s_wmask[0]) m_msip = s_wdata[0];
          1: m_cmp = merge(m_cmp, s_wdata, s_wmask);
          2: for (int i = 0; i < 2; i++) begin
               m_base[i] = merge(pre[i], s_wdata, s_wmask);
               m_t0[i]   = cyc;
             end
          default: ;
        endcase
      end
    end
    check("rvalid_div1", {63'b0, rvalid1}, {63'b0, e_rvalid});
    check("rvalid_div4", {63'b0, rvalid4}, {63'b0, e_rvalid});
    if (e_rvalid) begin
      check("rdata_div1", rdata1, e_rdata[0]);
      check("rdata_div4", rdata4, e_rdata[1]);
    end
    check("mtime_div1", mtime1, mt(0));
    check("mtime_div4", mtime4, mt(1));
    check("mtip_div1", {63'b0, mtip1}, {63'b0, mt(0) >= m_cmp});
    check("mtip_div4", {63'b0, mtip4}, {63'b0, mt(1) >= m_cmp});
    check("msip_div1", {63'b0, msip1}, {63'b0, m_msip});
    check("msip_div4", {63'b0, msip4}, {63'b0, m_msip});
  endtask

  task automatic access(input logic w, input logic [63:0] a, input logic [63:0] d,
                        input logic [7:0] m);
    valid = 1'b1; wen = w; addr = a; wdata = d; wmask = m;
    tick();
    valid = 1'b0; wen = 1'b0;
  endtask

  initial begin
    int          r;
    logic [63:0] a, d;
    logic [7:0]  m;
    m_div[0] = 1;
    m_div[1] = 4;

    // 1: reset then idle
    rst = 1'b1;
    tick();
    check("reset_mtime", mtime1, 64'd0);
    check("ready", {63'b0, ready1 & ready4}, 64'd1);
    rst = 1'b0;
    repeat (10) tick();
    check("t1_mtime10", mtime1, 64'd10);
    check("t1_mtip", {63'b0, mtip1}, 64'd0);

    // 2: mtimecmp compare
    access(1'b1, A_CMP, 64'd20, 8'hFF);
    repeat (8) tick();
    check("t2_mtip_before", {63'b0, mtip1}, 64'd0);
    tick();
    check("t2_mtime20", mtime1, 64'd20);
    check("t2_mtip_rise", {63'b0, mtip1}, 64'd1);
    access(1'b1, A_CMP, ONES, 8'hFF);
    check("t2_mtip_clear", {63'b0, mtip1}, 64'd0);

    // 3: msip
    access(1'b1, A_MSIP, 64'd1, 8'hFF);
    check("t3_msip_set", {63'b0, msip1}, 64'd1);
    check("t3_wr_rdata", rdata1, 64'd0);
    access(1'b0, A_MSIP, '0, 8'h00);
    check("t3_rd_msip1", rdata1, 64'd1);
    access(1'b1, A_MSIP, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    check("t3_msip_clr", {63'b0, msip1}, 64'd0);
    access(1'b0, A_MSIP, '0, 8'h00);
    check("t3_rd_msip0", rdata1, 64'd0);

    // 4: partial mtimecmp write
    rst = 1'b1;
    tick();
    rst = 1'b0;
    access(1'b1, A_CMP, 64'h1122_3344_5566_7788, 8'h0F);
    access(1'b0, A_CMP, '0, 8'h00);
    check("t4_cmp_partial", rdata1, 64'hFFFF_FFFF_5566_7788);

    // 5: mtime wrap and prescaler restart
    access(1'b1, A_MTIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    check("t5_fe", mtime1, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    check("t5_ff", mtime1, ONES);
    tick();
    check("t5_wrap", mtime1, 64'd0);
    access(1'b1, A_MTIME, 64'd5, 8'hFF);
    check("t5_div4_set", mtime4, 64'd5);
    repeat (3) tick();
    check("t5_div4_hold", mtime4, 64'd5);
    tick();
    check("t5_div4_inc", mtime4, 64'd6);

    // 6: unmapped reads and reset with a pending response
    access(1'b0, BASE + 64'h8, '0, 8'h00);
    check("t6_rd_hole", rdata1, 64'd0);
    access(1'b0, BASE + 64'h1_0000, '0, 8'h00);
    check("t6_rd_outside", rdata1, 64'd0);
    access(1'b1, A_CMP, 64'd3, 8'hFF);
    valid = 1'b1; wen = 1'b0; addr = A_MTIME;
    tick();
    valid = 1'b1; wen = 1'b1; addr = A_CMP; wdata = 64'd0; wmask = 8'hFF;
    rst = 1'b1;
    tick();
    check("t6_rvalid_drop", {63'b0, rvalid1}, 64'd0);
    valid = 1'b0; wen = 1'b0; rst = 1'b0;
    access(1'b0, A_CMP, '0, 8'h00);
    check("t6_cmp_reset", rdata1, ONES);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        rst = 1'b1;
        valid = $urandom_range(0, 1) == 1;
        tick();
        rst = 1'b0;
        valid = 1'b0;
      end else if (r < 65) begin
        case ($urandom_range(0, 6))
          0: a = A_MSIP;
          1, 2: a = A_CMP;
          3: a = A_MTIME;
          4: a = BASE + 64'h8;
          5: a = BASE - 64'h8;
          default: a = BASE + 64'({$urandom} & 32'h0001_FFFF);
        endcase
        d = {$urandom, $urandom};
        if (a == A_CMP && $urandom_range(0, 1) == 1) d = mt(0) + 64'($urandom_range(0, 12));
        if (a == A_MTIME && $urandom_range(0, 1) == 1) d = ONES - 64'($urandom_range(0, 5));
        m = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
        access($urandom_range(0, 1) == 1, a, d, m);
      end else begin
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
